// File: rtl/spatz_vsldu_sequencer.sv
// Purpose: in-order request queue and IDLE/ISSUE/WAIT sequencer feeding the single-issue vector slide unit.
// Latency: issue_valid_o rises 1 cycle after a queue pop; done_valid_o pulses 1 cycle after the matching response (or after a vl=0 pop).
// Backpressure: req_ready_o is a registered queue-not-full flag; issue fields are held stable until issue_ready_i.
// Optional: define SPATZ_VSLDU_SEQ_PERF_EN to add saturating perf_issued_o / perf_stall_o counters.
module spatz_vsldu_sequencer #(
  parameter int unsigned NrSlots      = 4,
  parameter int unsigned IdWidth      = 3,
  parameter int unsigned VlWidth      = 16,
  parameter int unsigned PayloadWidth = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [IdWidth-1:0]      req_id_i,
  input  logic [4:0]              req_vd_i,
  input  logic [4:0]              req_vs2_i,
  input  logic [VlWidth-1:0]      req_vl_i,
  input  logic [PayloadWidth-1:0] req_payload_i,
  output logic                    issue_valid_o,
  input  logic                    issue_ready_i,
  output logic [IdWidth-1:0]      issue_id_o,
  output logic [4:0]              issue_vd_o,
  output logic [4:0]              issue_vs2_o,
  output logic [VlWidth-1:0]      issue_vl_o,
  output logic [PayloadWidth-1:0] issue_payload_o,
  input  logic                    rsp_valid_i,
  input  logic [IdWidth-1:0]      rsp_id_i,
  output logic                    done_valid_o,
  output logic [IdWidth-1:0]      done_id_o,
  input  logic                    flush_i,
  output logic                    busy_o,
  output logic                    error_o
`ifdef SPATZ_VSLDU_SEQ_PERF_EN
  ,
  output logic [31:0]             perf_issued_o,
  output logic [31:0]             perf_stall_o
`endif
);

  localparam int unsigned PtrW = $clog2(NrSlots);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [IdWidth-1:0]      id;
    logic [4:0]              vd;
    logic [4:0]              vs2;
    logic [VlWidth-1:0]      vl;
    logic [PayloadWidth-1:0] payload;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  req_t                mem_q [NrSlots];
  req_t                req_in, head, issue_q;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q, count_d;
  logic                ready_q, push, pop, head_vld, head_nz;
  state_e              state_q, state_d;
  logic                load_issue;
  logic                issue_valid_q, issue_valid_d;
  logic [IdWidth-1:0]  inflight_q, inflight_d;
  logic                done_valid_q, done_valid_d;
  logic [IdWidth-1:0]  done_id_q, done_id_d;
  logic                error_q, error_d;

  assign req_in   = '{id: req_id_i, vd: req_vd_i, vs2: req_vs2_i, vl: req_vl_i, payload: req_payload_i};
  assign head     = mem_q[rd_ptr_q];
  assign head_vld = (count_q != '0);
  assign head_nz  = head_vld && (head.vl != '0);
  assign push     = req_valid_i && ready_q;

  // Next occupancy; a flush empties the queue regardless of concurrent push/pop.
  always_comb begin
    count_d = count_q;
    if (flush_i) count_d = '0;
    else         count_d = count_q + CntW'(push) - CntW'(pop);
  end

  // Queue storage: data path only, no reset needed.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem_q[wr_ptr_q] <= req_in;
  end

  // Queue pointers, count and the registered not-full flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d != CntW'(NrSlots));
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Sequencer next state: pop/issue, handshake, response matching and error detection.
  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    load_issue    = 1'b0;
    issue_valid_d = issue_valid_q;
    inflight_d    = inflight_q;
    done_valid_d  = 1'b0;
    done_id_d     = '0;
    error_d       = error_q;
    unique case (state_q)
      IDLE: begin
        if (rsp_valid_i) error_d = 1'b1;
        if (head_vld) begin
          pop = 1'b1;
          if (head_nz) begin
            load_issue    = 1'b1;
            issue_valid_d = 1'b1;
            state_d       = ISSUE;
          end else begin
            // Zero-length request retires without touching the slide unit.
            done_valid_d = 1'b1;
            done_id_d    = head.id;
          end
        end
      end
      ISSUE: begin
        if (rsp_valid_i) error_d = 1'b1;
        if (issue_ready_i) begin
          issue_valid_d = 1'b0;
          inflight_d    = issue_q.id;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        if (rsp_valid_i) begin
          if (rsp_id_i == inflight_q) begin
            done_valid_d = 1'b1;
            done_id_d    = inflight_q;
            if (head_nz) begin
              pop           = 1'b1;
              load_issue    = 1'b1;
              issue_valid_d = 1'b1;
              state_d       = ISSUE;
            end else begin
              state_d = IDLE;
            end
          end else begin
            error_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers: state, issue port, in-flight tag, done pulse, sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      issue_q       <= '0;
      issue_valid_q <= 1'b0;
      inflight_q    <= '0;
      done_valid_q  <= 1'b0;
      done_id_q     <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      if (load_issue) issue_q <= head;
      issue_valid_q <= issue_valid_d;
      inflight_q    <= inflight_d;
      done_valid_q  <= done_valid_d;
      done_id_q     <= done_id_d;
      error_q       <= error_d;
    end
  end

  assign req_ready_o     = ready_q;
  assign issue_valid_o   = issue_valid_q;
  assign issue_id_o      = issue_q.id;
  assign issue_vd_o      = issue_q.vd;
  assign issue_vs2_o     = issue_q.vs2;
  assign issue_vl_o      = issue_q.vl;
  assign issue_payload_o = issue_q.payload;
  assign done_valid_o    = done_valid_q;
  assign done_id_o       = done_id_q;
  assign error_o         = error_q;
  assign busy_o          = head_vld || (state_q != IDLE);

`ifdef SPATZ_VSLDU_SEQ_PERF_EN
  logic [31:0] perf_issued_q, perf_stall_q;

  // Saturating counters for issue handshakes and issue stall cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (issue_valid_q && issue_ready_i && (perf_issued_q != '1))
        perf_issued_q <= perf_issued_q + 32'd1;
      if (issue_valid_q && !issue_ready_i && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issued_o = perf_issued_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule
